// File: rtl/hs_fifo_flags_if.sv
// hs_fifo_flags_if: producer/consumer handshake, clear and status signals of the flag FIFO
interface hs_fifo_flags_if #(
    parameter int WIDTH     = 8,
    parameter int ADR_WIDTH = 5
);
    logic                 clear;
    logic                 tx_rdy;
    logic                 tx_done;
    logic [WIDTH-1:0]     in_data;
    logic                 rx_rdy;
    logic                 rx_done;
    logic [WIDTH-1:0]     out_data;
    logic                 empty;
    logic                 full;
    logic                 almost_empty;
    logic                 almost_full;
    logic [ADR_WIDTH:0]   level;
    modport master (
        output clear, tx_rdy, in_data, rx_done,
        input  tx_done, rx_rdy, out_data, empty, full, almost_empty, almost_full, level
    );
    modport slave (
        input  clear, tx_rdy, in_data, rx_done,
        output tx_done, rx_rdy, out_data, empty, full, almost_empty, almost_full, level
    );
endinterface

// File: rtl/hs_fifo_flags.sv
// hs_fifo_flags: 4-phase handshake circular FIFO with level, clear and programmable flags
module hs_fifo_flags #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 20,
    parameter int ADR_WIDTH = 5,
    parameter int AF_LEVEL  = 16,
    parameter int AE_LEVEL  = 2
) (
    input logic            clk,
    input logic            rst,
    hs_fifo_flags_if.slave bus
);
    localparam int LW = ADR_WIDTH + 1;
    typedef enum logic {TX_IDLE, TX_ACK} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_VALID, RX_ACK} rx_state_t;
    tx_state_t              r_tx_state, w_tx_next;
    rx_state_t              r_rx_state, w_rx_next;
    logic [WIDTH-1:0]       r_mem [DEPTH];
    logic [WIDTH-1:0]       r_out;
    logic [ADR_WIDTH-1:0]   r_wr_ptr, r_rd_ptr;
    logic [LW-1:0]          r_level, w_level_nxt;
    logic                   r_empty, r_full, r_ae, r_af;
    logic                   w_push, w_pop, w_load;

    // Pointers wrap at DEPTH-1 so non-power-of-two depths never alias
    function automatic logic [ADR_WIDTH-1:0] f_inc(input logic [ADR_WIDTH-1:0] p);
        return (p == ADR_WIDTH'(DEPTH - 1)) ? '0 : p + ADR_WIDTH'(1);
    endfunction

    // Push uses the registered full so a same-edge pop cannot open a slot early
    always_comb begin
        w_push    = (r_tx_state == TX_IDLE) && bus.tx_rdy && !r_full && !bus.clear;
        w_tx_next = w_push ? TX_ACK : ((r_tx_state == TX_ACK) && !bus.tx_rdy) ? TX_IDLE : r_tx_state;
    end

    // Consumer side: load from idle, pop on rx_done, clear aborts a presented word without popping
    always_comb begin
        w_load    = (r_rx_state == RX_IDLE) && !r_empty && !bus.clear;
        w_pop     = (r_rx_state == RX_VALID) && bus.rx_done && !bus.clear;
        w_rx_next = r_rx_state;
        case (r_rx_state)
            RX_IDLE:  w_rx_next = w_load ? RX_VALID : RX_IDLE;
            RX_VALID: w_rx_next = (bus.rx_done || bus.clear) ? RX_ACK : RX_VALID;
            RX_ACK:   w_rx_next = bus.rx_done ? RX_ACK : RX_IDLE;
            default:  w_rx_next = RX_IDLE;
        endcase
    end

    // Occupancy after this edge; a push and pop together cancel out
    always_comb begin
        w_level_nxt = bus.clear           ? '0 :
                      (w_push && !w_pop)  ? r_level + LW'(1) :
                      (w_pop && !w_push)  ? r_level - LW'(1) : r_level;
    end

    // State registers for both handshake FSMs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_state <= TX_IDLE;
            r_rx_state <= RX_IDLE;
        end else begin
            r_tx_state <= w_tx_next;
            r_rx_state <= w_rx_next;
        end
    end

    // Pointers, level and flags all move on the same edge
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_empty  <= 1'b1;
            r_full   <= 1'b0;
            r_ae     <= 1'b1;
            r_af     <= 1'b0;
        end else begin
            r_wr_ptr <= bus.clear ? '0 : w_push ? f_inc(r_wr_ptr) : r_wr_ptr;
            r_rd_ptr <= bus.clear ? '0 : w_pop ? f_inc(r_rd_ptr) : r_rd_ptr;
            r_level  <= w_level_nxt;
            r_empty  <= w_level_nxt == '0;
            r_full   <= w_level_nxt == LW'(DEPTH);
            r_ae     <= w_level_nxt <= LW'(AE_LEVEL);
            r_af     <= w_level_nxt >= LW'(AF_LEVEL);
        end
    end

    // Storage write; contents need no reset
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= bus.in_data;
    end

    // Output word is captured when the RX FSM leaves idle and held otherwise
    always_ff @(posedge clk) begin
        if (rst) r_out <= '0;
        else if (w_load) r_out <= r_mem[r_rd_ptr];
    end

    assign bus.tx_done      = r_tx_state == TX_ACK;
    assign bus.rx_rdy       = r_rx_state == RX_VALID;
    assign bus.out_data     = r_out;
    assign bus.level        = r_level;
    assign bus.empty        = r_empty;
    assign bus.full         = r_full;
    assign bus.almost_empty = r_ae;
    assign bus.almost_full  = r_af;
endmodule

// File: tb/tb_hs_fifo_flags.sv
// tb_hs_fifo_flags: directed self-checking bench for hs_fifo_flags
module tb_hs_fifo_flags;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_fail = 0;
    logic [7:0] exp_q[$];

    hs_fifo_flags_if #(.WIDTH(8), .ADR_WIDTH(5)) bus ();

    hs_fifo_flags #(
        .WIDTH(8), .DEPTH(20), .ADR_WIDTH(5), .AF_LEVEL(16), .AE_LEVEL(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_flags(input string tag);
        int n;
        n = exp_q.size();
        chk({tag, "_level"}, 32'(bus.level), n);
        chk({tag, "_empty"}, 32'(bus.empty), 32'(n == 0));
        chk({tag, "_full"}, 32'(bus.full), 32'(n == 20));
        chk({tag, "_ae"}, 32'(bus.almost_empty), 32'(n <= 2));
        chk({tag, "_af"}, 32'(bus.almost_full), 32'(n >= 16));
    endtask

    task automatic push(input logic [7:0] d);
        int n;
        bus.tx_rdy  = 1'b1;
        bus.in_data = d;
        n = 0;
        do begin
            tick;
            n++;
        end while (!bus.tx_done && n < 8);
        chk("push_ack", 32'(bus.tx_done), 1);
        exp_q.push_back(d);
        chk_flags("push");
        bus.tx_rdy = 1'b0;
        tick;
        chk("push_release", 32'(bus.tx_done), 0);
    endtask

    task automatic pop;
        int n;
        n = 0;
        while (!bus.rx_rdy && n < 8) begin
            tick;
            n++;
        end
        chk("pop_rdy", 32'(bus.rx_rdy), 1);
        chk("pop_data", 32'(bus.out_data), 32'(exp_q.pop_front()));
        bus.rx_done = 1'b1;
        tick;
        chk("pop_rdy_low", 32'(bus.rx_rdy), 0);
        chk_flags("pop");
        bus.rx_done = 1'b0;
        tick;
    endtask

    initial begin
        bus.clear   = 1'b0;
        bus.tx_rdy  = 1'b0;
        bus.in_data = '0;
        bus.rx_done = 1'b0;
        tick;
        tick;
        rst = 1'b0;
        chk("rst_tx_done", 32'(bus.tx_done), 0);
        chk("rst_rx_rdy", 32'(bus.rx_rdy), 0);
        chk("rst_out_data", 32'(bus.out_data), 0);
        chk_flags("rst");

        bus.tx_rdy  = 1'b1;
        bus.in_data = 8'hA5;
        tick;
        chk("t1_tx_done", 32'(bus.tx_done), 1);
        chk("t1_level", 32'(bus.level), 1);
        chk("t1_empty", 32'(bus.empty), 0);
        chk("t1_rx_rdy_early", 32'(bus.rx_rdy), 0);
        bus.tx_rdy = 1'b0;
        tick;
        chk("t1_rx_rdy", 32'(bus.rx_rdy), 1);
        chk("t1_out_data", 32'(bus.out_data), 32'h A5);
        bus.rx_done = 1'b1;
        tick;
        chk("t1_pop_level", 32'(bus.level), 0);
        chk("t1_pop_empty", 32'(bus.empty), 1);
        bus.rx_done = 1'b0;
        tick;

        for (int i = 0; i < 20; i++) push(8'(i));
        chk("t2_full", 32'(bus.full), 1);
        bus.tx_rdy  = 1'b1;
        bus.in_data = 8'h14;
        for (int i = 0; i < 3; i++) begin
            tick;
            chk("t2_refused", 32'(bus.tx_done), 0);
        end
        bus.tx_rdy = 1'b0;
        tick;
        chk("t2_level_full", 32'(bus.level), 20);
        for (int i = 0; i < 20; i++) pop;
        chk("t2_empty", 32'(bus.empty), 1);

        for (int i = 0; i < 15; i++) push(8'h20 + 8'(i));
        for (int i = 0; i < 15; i++) pop;
        for (int i = 0; i < 16; i++) push(8'h30 + 8'(i));
        for (int i = 0; i < 16; i++) pop;

        for (int i = 0; i < 5; i++) push(8'h40 + 8'(i));
        for (int i = 0; i < 8 && !bus.rx_rdy; i++) tick;
        chk("t4_rx_rdy", 32'(bus.rx_rdy), 1);
        chk("t4_head", 32'(bus.out_data), 32'h40);
        bus.tx_rdy  = 1'b1;
        bus.in_data = 8'h45;
        bus.rx_done = 1'b1;
        tick;
        void'(exp_q.pop_front());
        exp_q.push_back(8'h45);
        chk("t4_tx_done", 32'(bus.tx_done), 1);
        chk("t4_rx_rdy_low", 32'(bus.rx_rdy), 0);
        chk_flags("t4");
        chk("t4_level5", 32'(bus.level), 5);
        bus.tx_rdy  = 1'b0;
        bus.rx_done = 1'b0;
        tick;
        for (int i = 0; i < 5; i++) pop;

        for (int i = 0; i < 3; i++) push(8'h50 + 8'(i));
        chk("t5_ae_at3", 32'(bus.almost_empty), 0);
        pop;
        chk("t5_ae_at2", 32'(bus.almost_empty), 1);
        for (int i = 3; i < 16; i++) push(8'h50 + 8'(i));
        chk("t5_level15", 32'(bus.level), 15);
        chk("t5_af_at15", 32'(bus.almost_full), 0);
        push(8'h60);
        chk("t5_af_at16", 32'(bus.almost_full), 1);
        pop;
        chk("t5_af_back15", 32'(bus.almost_full), 0);
        while (exp_q.size() > 0) pop;

        for (int i = 0; i < 7; i++) push(8'h70 + 8'(i));
        for (int i = 0; i < 8 && !bus.rx_rdy; i++) tick;
        chk("t6_rx_rdy", 32'(bus.rx_rdy), 1);
        bus.clear = 1'b1;
        tick;
        exp_q.delete();
        bus.clear = 1'b0;
        chk("t6_rx_rdy_low", 32'(bus.rx_rdy), 0);
        chk_flags("t6_clr");
        tick;
        chk("t6_level_held", 32'(bus.level), 0);
        bus.clear   = 1'b1;
        bus.tx_rdy  = 1'b1;
        bus.in_data = 8'h99;
        tick;
        chk("t6_no_tx_done", 32'(bus.tx_done), 0);
        chk("t6_no_level", 32'(bus.level), 0);
        bus.clear  = 1'b0;
        bus.tx_rdy = 1'b0;
        tick;
        chk("t6_still_empty", 32'(bus.empty), 1);
        chk("t6_no_rx_rdy", 32'(bus.rx_rdy), 0);
        push(8'h77);
        pop;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
